// File: rtl/pad_cfg_pkg.sv
// Shared definitions for the runtime pad-configuration controller:
// FSM encodings, pad-word field offsets, control address and status bits.
package pad_cfg_pkg;

  typedef logic [1:0] state_t;

  localparam state_t SAFE     = 2'd0;
  localparam state_t DRAIN    = 2'd1;
  localparam state_t STAGE_IN = 2'd2;
  localparam state_t LIVE     = 2'd3;

  localparam int IE_BIT   = 8;
  localparam int OEN_BIT  = 9;
  localparam int TECH_LSB = 16;

  // All-ones; the top slices it down to its address width.
  localparam logic [31:0] CTRL_ADDR = 32'hFFFF_FFFF;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_SAFE_BIT  = 3;

endpackage

// File: rtl/pad_cfg_shadow.sv
// Per-pad shadow register file: one write port, one combinational read port
// and a flat snapshot of every field for staging into the active registers.
module pad_cfg_shadow
  import pad_cfg_pkg::*;
#(
  parameter int NPADS = 36,
  parameter int CFGW  = 8,
  parameter int TECHW = 16,
  parameter int IW    = $clog2(NPADS)
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   we,
  input  logic [IW-1:0]          waddr,
  input  logic [31:0]            wdata,
  input  logic [IW-1:0]          raddr,
  output logic [31:0]            rdata,
  output logic [NPADS*CFGW-1:0]  snap_cfg,
  output logic [NPADS-1:0]       snap_ie,
  output logic [NPADS-1:0]       snap_oen,
  output logic [NPADS*TECHW-1:0] snap_tech
);

  logic [CFGW-1:0]  cfg_q  [NPADS];
  logic [TECHW-1:0] tech_q [NPADS];
  logic [NPADS-1:0] ie_q;
  logic [NPADS-1:0] oen_q;

  // Only the defined fields are stored; the remaining write bits are dropped.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // NOTE: this register file is reset explicitly because software relies on
  // reading back the documented defaults; it therefore cannot map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int i = 0; i < NPADS; i++) begin
        cfg_q[i]  <= '0;
        tech_q[i] <= '0;
      end
      ie_q  <= '0;
      oen_q <= '1;
    end else if (we) begin
      cfg_q[waddr]  <= wdata[CFGW-1:0];
      tech_q[waddr] <= wdata[TECH_LSB +: TECHW];
      ie_q[waddr]   <= wdata[IE_BIT];
      oen_q[waddr]  <= wdata[OEN_BIT];
    end
  end

  // NOTE: the default assignment first keeps this block latch-free.
  always_comb begin
    rdata                      = '0;
    rdata[CFGW-1:0]            = cfg_q[raddr];
    rdata[IE_BIT]              = ie_q[raddr];
    rdata[OEN_BIT]             = oen_q[raddr];
    rdata[TECH_LSB +: TECHW]   = tech_q[raddr];
  end

  for (genvar i = 0; i < NPADS; i++) begin : g_snap
    assign snap_cfg[i*CFGW +: CFGW]   = cfg_q[i];
    assign snap_tech[i*TECHW +: TECHW] = tech_q[i];
  end

  assign snap_ie  = ie_q;
  assign snap_oen = oen_q;

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Pad-configuration controller: bus decode, staged commit FSM with settle
// counter, and the active cfg/ie/oen/tech_cfg registers feeding the padring.
module pad_cfg_ctrl
  import pad_cfg_pkg::*;
#(
  parameter int NPADS  = 36,
  parameter int CFGW   = 8,
  parameter int TECHW  = 16,
  parameter int SETTLE = 4,
  parameter int AW     = 8
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [AW-1:0]          req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  input  logic                   safe_req,
  output logic [NPADS*CFGW-1:0]  cfg,
  output logic [NPADS-1:0]       ie,
  output logic [NPADS-1:0]       oen,
  output logic [NPADS*TECHW-1:0] tech_cfg,
  output logic                   busy
);

  localparam int IW = $clog2(NPADS);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [AW-1:0] NPADS_A  = AW'(NPADS);
  localparam logic [AW-1:0] CTRL_A   = CTRL_ADDR[AW-1:0];

  state_t                   state_q;
  logic [CW-1:0]            settle_q;
  logic [NPADS-1:0]         oen_stage_q;
  logic                     accept, is_pad, is_ctrl, addr_err;
  logic                     commit_req, commit_go, shadow_we;
  logic [31:0]              shadow_rdata, ctrl_word, rdata_next;
  logic [NPADS*CFGW-1:0]    snap_cfg;
  logic [NPADS-1:0]         snap_ie, snap_oen;
  logic [NPADS*TECHW-1:0]   snap_tech;

  assign req_ready  = (state_q == SAFE) || (state_q == LIVE);
  assign busy       = (state_q == DRAIN) || (state_q == STAGE_IN);
  assign accept     = req_valid & req_ready;
  assign is_pad     = req_addr < NPADS_A;
  assign is_ctrl    = req_addr == CTRL_A;
  assign addr_err   = !(is_pad || is_ctrl);
  assign commit_req = accept & req_write & is_ctrl & req_wdata[0];
  assign commit_go  = commit_req & ~safe_req;
  assign shadow_we  = accept & req_write & is_pad;

  pad_cfg_shadow #(
    .NPADS (NPADS),
    .CFGW  (CFGW),
    .TECHW (TECHW),
    .IW    (IW)
  ) u_shadow (
    .clk       (clk),
    .nreset    (nreset),
    .we        (shadow_we),
    .waddr     (req_addr[IW-1:0]),
    .wdata     (req_wdata),
    .raddr     (req_addr[IW-1:0]),
    .rdata     (shadow_rdata),
    .snap_cfg  (snap_cfg),
    .snap_ie   (snap_ie),
    .snap_oen  (snap_oen),
    .snap_tech (snap_tech)
  );

  always_comb begin
    ctrl_word                           = '0;
    ctrl_word[STAT_STATE_LSB +: 2]      = state_q;
    ctrl_word[STAT_BUSY_BIT]            = busy;
    ctrl_word[STAT_SAFE_BIT]            = safe_req;
    rdata_next                          = '0;
    if (!req_write && !addr_err)
      rdata_next = is_ctrl ? ctrl_word : shadow_rdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept & (addr_err | (commit_req & safe_req));
      rsp_rdata <= accept ? rdata_next : '0;
    end
  end

  // safe_req shares the reset branch: it wins over any commit or settle in flight.
  always_ff @(posedge clk) begin
    if (!nreset || safe_req) begin
      state_q     <= SAFE;
      settle_q    <= '0;
      oen_stage_q <= '1;
      cfg         <= '0;
      ie          <= '0;
      oen         <= '1;
      tech_cfg    <= '0;
    end else begin
      case (state_q)
        SAFE: if (commit_go) begin
          state_q     <= STAGE_IN;
          settle_q    <= SETTLE_C;
          cfg         <= snap_cfg;
          ie          <= snap_ie;
          tech_cfg    <= snap_tech;
          oen_stage_q <= snap_oen;
        end
        LIVE: if (commit_go) begin
          state_q <= DRAIN;
          oen     <= '1;
        end
        DRAIN: begin
          state_q     <= STAGE_IN;
          settle_q    <= SETTLE_C;
          cfg         <= snap_cfg;
          ie          <= snap_ie;
          tech_cfg    <= snap_tech;
          oen_stage_q <= snap_oen;
        end
        default: begin
          // Output enables are released from the copy taken at staging entry.
          if (settle_q <= CW'(1)) begin
            state_q  <= LIVE;
            settle_q <= '0;
            oen      <= oen_stage_q;
          end else begin
            settle_q <= settle_q - CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Directed self-checking bench for pad_cfg_ctrl: reset defaults, shadow
// writes, staged commit timing, drain, safe override, bad addresses, reset abort.
module tb_pad_cfg_ctrl;
  import pad_cfg_pkg::*;

  localparam int NPADS = 36, CFGW = 8, TECHW = 16, SETTLE = 4, AW = 8;
  localparam logic [NPADS-1:0] ONES = '1;
  localparam logic [AW-1:0]    CTRL = 8'hFF;

  logic                   clk = 1'b0;
  logic                   nreset = 1'b0;
  logic                   req_valid = 1'b0, req_write = 1'b0, safe_req = 1'b0;
  logic [AW-1:0]          req_addr = '0;
  logic [31:0]            req_wdata = '0;
  logic                   req_ready, rsp_valid, rsp_err, busy;
  logic [31:0]            rsp_rdata;
  logic [NPADS*CFGW-1:0]  cfg;
  logic [NPADS-1:0]       ie, oen;
  logic [NPADS*TECHW-1:0] tech_cfg;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic        er;
  int          n;

  pad_cfg_ctrl #(
    .NPADS(NPADS), .CFGW(CFGW), .TECHW(TECHW), .SETTLE(SETTLE), .AW(AW)
  ) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .safe_req(safe_req), .cfg(cfg), .ie(ie), .oen(oen), .tech_cfg(tech_cfg),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  // One bus transaction; returns at the negedge after acceptance, when the
  // registered response is visible.
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output logic err);
    int waits = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) begin
      check("req_ready_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0; rdata = '0; err = 1'b1;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
    rdata = rsp_rdata; err = rsp_err;
    check("rsp_valid", 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset defaults
    tick(3);
    nreset = 1'b1;
    check("rst_oen", 64'(oen), 64'(ONES));
    check("rst_ie", 64'(ie), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cfg0", 64'(cfg[0 +: CFGW]), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    xfer(1'b0, 8'd0, 32'd0, rd, er);
    check("rd_pad0", 64'(rd), 64'h0000_0200);
    check("rd_pad0_err", 64'(er), 64'd0);
    tick(1);
    check("rsp_pulse_one_cycle", 64'(rsp_valid), 64'd0);

    // Shadow write leaves active outputs alone
    xfer(1'b1, 8'd5, 32'h00AB_01FF, rd, er);
    check("wr_rdata_zero", 64'(rd), 64'd0);
    check("wr_no_apply_ie", 64'(ie), 64'd0);
    check("wr_no_apply_cfg5", 64'(cfg[5*CFGW +: CFGW]), 64'd0);
    xfer(1'b0, 8'd5, 32'd0, rd, er);
    check("rd_pad5", 64'(rd), 64'h00AB_01FF);

    // Commit from SAFE: STAGE_IN right after the edge, LIVE SETTLE edges later
    xfer(1'b1, CTRL, 32'd1, rd, er);
    check("c1_err", 64'(er), 64'd0);
    check("c1_ie5", 64'(ie[5]), 64'd1);
    check("c1_cfg5", 64'(cfg[5*CFGW +: CFGW]), 64'hFF);
    check("c1_tech5", 64'(tech_cfg[5*TECHW +: TECHW]), 64'h00AB);
    check("c1_oen5", 64'(oen[5]), 64'd1);
    check("c1_busy", 64'(busy), 64'd1);
    tick(SETTLE - 1);
    check("c1_oen5_settling", 64'(oen[5]), 64'd1);
    tick(1);
    check("c1_oen_live", 64'(oen), 64'(ONES & ~(36'd1 << 5)));
    check("c1_busy_live", 64'(busy), 64'd0);
    xfer(1'b0, CTRL, 32'd0, rd, er);
    check("ctrl_live", 64'(rd), 64'h3);

    // Commit from LIVE: one DRAIN cycle, then STAGE_IN, ready low 1+SETTLE cycles
    xfer(1'b1, 8'd5, 32'h0012_0034, rd, er);
    xfer(1'b1, CTRL, 32'd1, rd, er);
    check("drain_oen", 64'(oen), 64'(ONES));
    check("drain_cfg5_held", 64'(cfg[5*CFGW +: CFGW]), 64'hFF);
    check("drain_ie5_held", 64'(ie[5]), 64'd1);
    check("drain_busy", 64'(busy), 64'd1);
    n = 1;
    tick(1);
    check("stage_cfg5", 64'(cfg[5*CFGW +: CFGW]), 64'h34);
    check("stage_tech5", 64'(tech_cfg[5*TECHW +: TECHW]), 64'h0012);
    check("stage_ie5", 64'(ie[5]), 64'd0);
    check("stage_oen", 64'(oen), 64'(ONES));
    while (!req_ready && n < 50) begin
      n++;
      tick(1);
    end
    check("ready_low_cycles", 64'(n), 64'(1 + SETTLE));
    check("c2_oen_live", 64'(oen), 64'(ONES & ~(36'd1 << 5)));

    // safe_req on the second STAGE_IN cycle forces SAFE on the next edge
    xfer(1'b1, CTRL, 32'd1, rd, er);
    tick(2);
    safe_req = 1'b1;
    tick(1);
    check("safe_oen", 64'(oen), 64'(ONES));
    check("safe_ie", 64'(ie), 64'd0);
    check("safe_cfg5", 64'(cfg[5*CFGW +: CFGW]), 64'd0);
    check("safe_busy", 64'(busy), 64'd0);
    xfer(1'b1, CTRL, 32'd1, rd, er);
    check("safe_commit_err", 64'(er), 64'd1);
    xfer(1'b0, CTRL, 32'd0, rd, er);
    check("safe_ctrl", 64'(rd), 64'h8);
    safe_req = 1'b0;
    xfer(1'b1, CTRL, 32'd1, rd, er);
    check("resume_err", 64'(er), 64'd0);
    tick(SETTLE);
    check("resume_cfg5", 64'(cfg[5*CFGW +: CFGW]), 64'h34);
    check("resume_tech5", 64'(tech_cfg[5*TECHW +: TECHW]), 64'h0012);
    check("resume_oen", 64'(oen), 64'(ONES & ~(36'd1 << 5)));

    // Out-of-range addresses
    xfer(1'b0, 8'(NPADS), 32'd0, rd, er);
    check("bad_rd_err", 64'(er), 64'd1);
    check("bad_rd_data", 64'(rd), 64'd0);
    xfer(1'b1, 8'hFE, 32'hFFFF_FFFF, rd, er);
    check("bad_wr_err", 64'(er), 64'd1);
    check("bad_no_change", 64'(busy), 64'd0);
    xfer(1'b0, CTRL, 32'd0, rd, er);
    check("bad_ctrl_live", 64'(rd), 64'h3);

    // Reset during DRAIN restores everything, including the shadow
    xfer(1'b1, CTRL, 32'd1, rd, er);
    check("pre_rst_drain_busy", 64'(busy), 64'd1);
    nreset = 1'b0;
    tick(1);
    check("abort_oen", 64'(oen), 64'(ONES));
    check("abort_ie", 64'(ie), 64'd0);
    check("abort_cfg5", 64'(cfg[5*CFGW +: CFGW]), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    nreset = 1'b1;
    xfer(1'b0, 8'd5, 32'd0, rd, er);
    check("abort_shadow5", 64'(rd), 64'h0000_0200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_cfg_ctrl.md
# pad_cfg_ctrl

Runtime pad-configuration controller that replaces the tied-off `*_cfg`/`*_ie`/`*_oen`/`*_tech_cfg` nets feeding the padring. Software writes per-pad settings into shadow registers over a simple request/response bus. A commit command then applies them through a safe staged sequence: outputs are disabled, configuration and input enables are applied, a settle period elapses, and only then are output enables released. Sits between the core's control bus and `oh_padring`, one instance per die, with pad count generalised by parameter.

## Interface
- `NPADS`, 36, total pads; side order is WE, NO, SO, EA, pad 0 at the LSB.
- `CFGW`, 8, cfg bits per pad; must be ≤ 8.
- `TECHW`, 16, tech_cfg bits per pad; must be ≤ 16.
- `SETTLE`, 4, cycles between input/config apply and output enable release; must be ≥ 1.
- `AW`, 8, address width; 2^AW − 1 must exceed NPADS − 1.

Ports:
- `clk` in 1: sole clock.
- `nreset` in 1: reset, synchronous and active-low.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in AW: pad index, or `CTRL_ADDR` (all-ones).
- `req_wdata` in 32: write data.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: read data; 0 for writes.
- `rsp_err` out 1: error flag, qualified by `rsp_valid`.
- `safe_req` in 1: level; forces the SAFE state.
- `cfg` out NPADS*CFGW: active pad config.
- `ie` out NPADS: active input enables.
- `oen` out NPADS: active output enable-bar.
- `tech_cfg` out NPADS*TECHW: active tech config.
- `busy` out 1: high in DRAIN or STAGE_IN.

## Operation
- Pad word layout:
  - [CFGW-1:0] cfg
  - [8] ie
  - [9] oen
  - [16+TECHW-1:16] tech_cfg
  - unused bits write-ignored, read 0.
- Write with addr < NPADS updates that pad's shadow; it never touches active outputs. Allowed in every state.
- Read with addr < NPADS returns the shadow word.
- Read of `CTRL_ADDR` returns [1:0] state, [2] busy, [3] safe_req.
- Write of `CTRL_ADDR` with wdata[0]=1 is a commit; wdata[0]=0 is a no-op.
- Any other address returns `rsp_err`=1, with no effect and rdata 0.
- FSM states:
  - SAFE: outputs at reset values.
  - DRAIN: oen all-ones; cfg, ie and tech_cfg hold their previous active values.
  - STAGE_IN: cfg, ie and tech_cfg = shadow; oen all-ones.
  - LIVE: all outputs = active registers.
- Transitions:
  - SAFE –commit→ STAGE_IN.
  - LIVE –commit→ DRAIN → STAGE_IN after 1 cycle.
  - STAGE_IN → LIVE after SETTLE cycles; oen loads from shadow on entry.
  - Any state with `safe_req`=1 → SAFE on the next edge. Shadow registers are retained.
- Commit while `safe_req`=1: accepted with `rsp_err`=1; state unchanged.
- Shadow writes during STAGE_IN do not alter the staging in progress. They take effect on the next commit.

## Timing
- Reset values:
  - State SAFE.
  - cfg=0, ie=0, oen=all-ones, tech_cfg=0.
  - Shadow cfg=0, ie=0, oen=1, tech=0 per pad.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0.
- `req_ready`=1 in SAFE and LIVE; 0 in DRAIN and STAGE_IN.
- One transaction at a time. The response is registered: `rsp_valid` is high exactly one cycle after acceptance. There is no response backpressure.
- Commit accepted at edge E0:
  - from LIVE: DRAIN after E0; STAGE_IN after E1; LIVE after E1+SETTLE.
  - from SAFE: STAGE_IN after E0; LIVE after E0+SETTLE.
- The settle counter is $clog2(SETTLE+1) bits wide. It loads SETTLE on STAGE_IN entry and decrements to 0 with no wrap.
- `safe_req` beats an in-flight commit or settle; it wins on the same edge. An accepted request still gets its response.
- `nreset` mid-sequence aborts on the next edge and restores all reset values, including shadow.

## Structure
- Package `pad_cfg_pkg` holds:
  - the state enum (SAFE, DRAIN, STAGE_IN, LIVE);
  - field offsets (IE_BIT=8, OEN_BIT=9, TECH_LSB=16);
  - `CTRL_ADDR`;
  - the status bit positions.
- Sub-module `pad_cfg_shadow` holds the NPADS-entry shadow register file with a write port, a read port and a flat snapshot output.
- The top level holds the FSM, the settle counter, the bus response logic and the active output registers.

## Test plan
- Reset, then read pad 0 → rdata 0x0000_0200. Outputs: oen all-ones, ie 0, busy 0.
- Write pad 5 = 0x00AB_01FF with no commit → outputs unchanged. Then commit → after 1 cycle ie[5]=1, cfg[5]=0xFF, tech[5]=0xAB, oen[5]=1. SETTLE cycles later oen[5]=0, with state LIVE.
- Commit from LIVE → exactly one DRAIN cycle with oen all-ones and old cfg held. Then STAGE_IN, then LIVE. `req_ready`=0 for 1+SETTLE cycles.
- Assert `safe_req` at cycle 2 of STAGE_IN → next edge SAFE with reset outputs. A following commit gets `rsp_err`=1 while `safe_req` is held. After release, commit restores the shadowed values.
- Access addr NPADS → `rsp_err`=1, rdata 0, no state change. Read `CTRL_ADDR` in LIVE → rdata[1:0]=3.
- Pulse `nreset` low during DRAIN → next edge all reset values, and shadow reads return 0x0000_0200.
